// File: rtl/unpacker_pkg.sv
// Shared constants, prefix enums and the code-length table for the block unpacker.
package unpacker_pkg;

    localparam int WIDTH  = 128;
    localparam int CODE   = 2;
    localparam int WORD   = 16;
    localparam int IDX_W  = $clog2(WORD);
    localparam int LENGTH = 6;
    localparam int ACC_W  = $clog2(WIDTH);

    typedef enum logic [CODE-1:0] {
        ZZZZ = 2'b00,
        XXXX = 2'b01,
        MMMM = 2'b10,
        EXT  = 2'b11
    } prefix_e;

    typedef enum logic [CODE-1:0] {
        EXT_24 = 2'b00,
        EXT_12 = 2'b01,
        EXT_16 = 2'b10,
        EXT_32 = 2'b11
    } sub_prefix_e;

    function automatic logic [LENGTH-1:0] code_length(input prefix_e code, input sub_prefix_e bak);
        logic [LENGTH-1:0] len;
        case (code)
            ZZZZ:    len = LENGTH'(2);
            XXXX:    len = LENGTH'(34);
            MMMM:    len = LENGTH'(6);
            default: begin
                case (bak)
                    EXT_24:  len = LENGTH'(24);
                    EXT_12:  len = LENGTH'(12);
                    EXT_16:  len = LENGTH'(16);
                    default: len = LENGTH'(32);
                endcase
            end
        endcase
        return len;
    endfunction

endpackage

// File: rtl/unpacker_length_generator.sv
// Maps a prefix / sub-prefix pair to the total bit length of that code.
module length_generator
    import unpacker_pkg::*;
(
    input  logic [CODE-1:0]   code,
    input  logic [CODE-1:0]   code_bak,
    output logic [LENGTH-1:0] length
);

    assign length = code_length(prefix_e'(code), sub_prefix_e'(code_bak));

endmodule

// File: rtl/unpacker.sv
// Decodes two variable-length codes per cycle from the LSB end of a packed
// block, then shifts both out; zero fill past the end decodes as short codes.
module unpacker
    import unpacker_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_update,
    input  logic [WIDTH-1:0]  i_data,
    output logic [CODE-1:0]   o_first_code,
    output logic [CODE-1:0]   o_first_code_bak,
    output logic [IDX_W-1:0]  o_idx1,
    output logic [CODE-1:0]   o_second_code,
    output logic [CODE-1:0]   o_second_code_bak,
    output logic [IDX_W-1:0]  o_idx2,
    output logic [LENGTH-1:0] o_first_length,
    output logic [LENGTH-1:0] o_second_length
);

    logic [WIDTH-1:0] data_p0;
    logic             vld_p0;
    logic [WIDTH-1:0] shifted_data_r;
    logic [WIDTH-1:0] second_shifted;
    logic [WIDTH-1:0] shifted_data_n;
    logic [ACC_W-1:0] total_length_next;

    // Stage p0: input block and its load request
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            data_p0 <= '0;
            vld_p0  <= 1'b0;
        end else begin
            data_p0 <= i_data;
            vld_p0  <= i_update;
        end
    end

    // Stage p1: working shift register; a staged load discards any remaining bits
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            shifted_data_r    <= '0;
            total_length_next <= '0;
        end else if (vld_p0) begin
            shifted_data_r    <= data_p0;
            total_length_next <= '0;
        end else begin
            shifted_data_r    <= shifted_data_n;
            total_length_next <= total_length_next + ACC_W'(o_first_length)
                                                   + ACC_W'(o_second_length);
        end
    end

    assign o_first_code     = shifted_data_r[CODE-1:0];
    assign o_first_code_bak = (o_first_code == EXT) ? shifted_data_r[CODE +: CODE] : '0;
    assign o_idx1           = (o_first_code == EXT) ? shifted_data_r[2*CODE +: IDX_W]
                                                    : shifted_data_r[CODE +: IDX_W];

    length_generator u_len1 (
        .code     (o_first_code),
        .code_bak (o_first_code_bak),
        .length   (o_first_length)
    );

    assign second_shifted = shifted_data_r >> o_first_length;

    assign o_second_code     = second_shifted[CODE-1:0];
    assign o_second_code_bak = (o_second_code == EXT) ? second_shifted[CODE +: CODE] : '0;
    assign o_idx2            = (o_second_code == EXT) ? second_shifted[2*CODE +: IDX_W]
                                                      : second_shifted[CODE +: IDX_W];

    length_generator u_len2 (
        .code     (o_second_code),
        .code_bak (o_second_code_bak),
        .length   (o_second_length)
    );

    assign shifted_data_n = second_shifted >> o_second_length;

endmodule

// File: tb/tb_unpacker.sv
// Directed bench for the unpacker: hand-computed vectors plus a bit-pointer reference walk.
module tb_unpacker;

    logic         clk;
    logic         i_reset;
    logic         i_update;
    logic [127:0] i_data;
    logic [1:0]   o_first_code, o_first_code_bak, o_second_code, o_second_code_bak;
    logic [3:0]   o_idx1, o_idx2;
    logic [5:0]   o_first_length, o_second_length;
    logic [27:0]  obs;

    int total = 0;
    int bad   = 0;
    int len_tab [8] = '{2, 34, 6, 0, 24, 12, 16, 32};

    localparam logic [127:0] BLK_A   = 128'h0000_0000_0000_00F3_0000_0000_0000_0000;
    localparam logic [127:0] BLK_B   = 128'h03FF_0000_0000_0000_0000_0000_0000_BBCC;
    localparam logic [127:0] BLK_C   = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    localparam logic [127:0] BLK_D   = 128'h0000_0000_0000_0000_0000_0000_0000_C0C0;
    localparam logic [127:0] BLK_SB1 = 128'h02AA_3F00_00B3_8891_1122_AABB_CC00_DD00;
    localparam logic [127:0] BLK_SB2 = 128'h1234_0000_0000_5678_0000_0000_0000_C0C0;

    unpacker dut (
        .i_clk             (clk),
        .i_reset           (i_reset),
        .i_update          (i_update),
        .i_data            (i_data),
        .o_first_code      (o_first_code),
        .o_first_code_bak  (o_first_code_bak),
        .o_idx1            (o_idx1),
        .o_second_code     (o_second_code),
        .o_second_code_bak (o_second_code_bak),
        .o_idx2            (o_idx2),
        .o_first_length    (o_first_length),
        .o_second_length   (o_second_length)
    );

    assign obs = {o_first_code, o_first_code_bak, o_idx1, o_first_length,
                  o_second_code, o_second_code_bak, o_idx2, o_second_length};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [27:0] pk(input logic [1:0] c1, input logic [1:0] b1,
                                       input logic [3:0] i1, input logic [5:0] l1,
                                       input logic [1:0] c2, input logic [1:0] b2,
                                       input logic [3:0] i2, input logic [5:0] l2);
        return {c1, b1, i1, l1, c2, b2, i2, l2};
    endfunction

    // Reference decode reading individual bits at an absolute position in the block.
    function automatic logic [13:0] model_code(input logic [127:0] blk, input int pos,
                                               output int len);
        logic [7:0] w;
        logic [1:0] c, b;
        logic [3:0] ix;
        for (int k = 0; k < 8; k++)
            w[k] = (pos + k < 128) ? blk[pos + k] : 1'b0;
        c = w[1:0];
        if (c == 2'b11) begin
            b   = w[3:2];
            ix  = w[7:4];
            len = len_tab[4 + int'(b)];
        end else begin
            b   = 2'b00;
            ix  = w[5:2];
            len = len_tab[int'(c)];
        end
        return {c, b, ix, 6'(len)};
    endfunction

    task automatic check(input string tag, input logic [27:0] got, input logic [27:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [127:0] d);
        i_update = 1'b1;
        i_data   = d;
        step();
        i_update = 1'b0;
        step();
    endtask

    task automatic scoreboard(input logic [127:0] blk, input string name);
        int pos, l1, l2;
        logic [13:0] m1, m2;
        load(blk);
        pos = 0;
        for (int n = 0; n < 64; n++) begin
            m1 = model_code(blk, pos, l1);
            m2 = model_code(blk, pos + l1, l2);
            check($sformatf("%s_c%0d", name, n), obs, {m1, m2});
            pos = pos + l1 + l2;
            step();
        end
    endtask

    initial begin
        logic [27:0] rst_v;
        rst_v    = pk(2'd0, 2'd0, 4'd0, 6'd2, 2'd0, 2'd0, 4'd0, 6'd2);
        i_reset  = 1'b1;
        i_update = 1'b0;
        i_data   = '0;
        step(2);
        check("reset", obs, rst_v);
        i_reset = 1'b0;

        load(BLK_A);
        check("a_load", obs, rst_v);
        step(15);
        check("a_adv15", obs, pk(2'd0, 2'd0, 4'd12, 6'd2, 2'd0, 2'd0, 4'd3, 6'd2));
        step();
        check("a_adv16", obs, pk(2'd3, 2'd0, 4'd15, 6'd24, 2'd0, 2'd0, 4'd0, 6'd2));

        load(BLK_B);
        check("b_load", obs, pk(2'd0, 2'd0, 4'd3, 6'd2, 2'd3, 2'd0, 4'd15, 6'd24));
        step();
        check("b_adv1", obs, rst_v);

        load(BLK_C);
        check("c_load", obs, rst_v);
        step(16);
        check("c_ones", obs, pk(2'd3, 2'd3, 4'd15, 6'd32, 2'd3, 2'd3, 4'd15, 6'd32));
        step();
        check("c_exhaust", obs, rst_v);

        load(BLK_D);
        check("d_load", obs, pk(2'd0, 2'd0, 4'd0, 6'd2, 2'd0, 2'd0, 4'd12, 6'd2));
        step();
        check("d_adv1", obs, pk(2'd0, 2'd0, 4'd3, 6'd2, 2'd3, 2'd0, 4'd0, 6'd24));
        step();
        check("d_adv2", obs, rst_v);

        scoreboard(BLK_SB1, "sb1");
        scoreboard(BLK_SB2, "sb2");

        // Reset mid-block, with an update request staged and still asserted.
        load(BLK_B);
        i_update = 1'b1;
        i_data   = BLK_D;
        step();
        i_reset = 1'b1;
        step();
        check("rst_mid", obs, rst_v);
        i_reset  = 1'b0;
        i_update = 1'b0;
        step();
        check("rst_stage_clr", obs, rst_v);

        // Update mid-block discards the rest of the current block.
        load(BLK_C);
        step(3);
        load(BLK_D);
        check("upd_mid", obs, pk(2'd0, 2'd0, 4'd0, 6'd2, 2'd0, 2'd0, 4'd12, 6'd2));

        // Back-to-back updates reload each cycle.
        i_update = 1'b1;
        i_data   = BLK_B;
        step();
        i_data = BLK_D;
        step();
        check("upd_b2b_1", obs, pk(2'd0, 2'd0, 4'd3, 6'd2, 2'd3, 2'd0, 4'd15, 6'd24));
        i_update = 1'b0;
        step();
        check("upd_b2b_2", obs, pk(2'd0, 2'd0, 4'd0, 6'd2, 2'd0, 2'd0, 4'd12, 6'd2));
        step();
        check("upd_b2b_adv", obs, pk(2'd0, 2'd0, 4'd3, 6'd2, 2'd3, 2'd0, 4'd0, 6'd24));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
